pool_buffer: RTL

Parametrised pooling-and-buffer stage for the CNN datapath. Each accepted beat reduces a window of POOL_N signed samples per channel to one value (max or average, optional ReLU) and pushes the CH-wide result into a circular buffer. The downstream layer or UART transmitter drains the buffer through a first-word-fall-through pop interface. The block is the generalised successor of the fixed 4-channel, 2x2 max-pool, 32-entry layer-3 buffer.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/pool_buffer_ram.sv | 28 ++
 rtl/pool_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: pooling mode selector and sample type.
package cnn_pkg;

    // Pooling reduction applied across one window of samples.
    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Default datapath sample width and the matching signed sample type.
    localparam int SAMPLE_DW = 18;

    typedef logic signed [SAMPLE_DW-1:0] sample_t;

endpackage

// File: rtl/pool_buffer_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// The asynchronous read gives the first-word-fall-through head in the
// same cycle the read pointer moves.
module pool_buffer_ram #(
    parameter int W     = 72,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port: store one reduced vector per accepted beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_buffer.sv
// Pooling-and-buffer stage: reduces a POOL_N-sample window per channel
// (max or floor-average, optional ReLU) and queues the CH-wide result in a
// circular buffer drained through a first-word-fall-through pop port.
module pool_buffer
    import cnn_pkg::*;
#(
    parameter int         DW     = 18,
    parameter int         CH     = 4,
    parameter int         POOL_N = 4,
    parameter int         DEPTH  = 32,
    parameter pool_mode_e MODE   = POOL_MAX,
    parameter int         RELU   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               wr_vld,
    input  logic [CH-1:0][POOL_N-1:0][DW-1:0]  din,
    output logic                               wr_rdy,
    input  logic                               rd_inc,
    output logic                               rd_vld,
    output logic [CH-1:0][DW-1:0]              dout,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               ovf,
    output logic                               udf
);

    localparam int LOG_N = $clog2(POOL_N);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = DW + LOG_N;

    // ------------------------------------------------------------------
    // Per-channel reduction (purely combinational on din)
    // ------------------------------------------------------------------
    logic [CH-1:0][DW-1:0] pooled;

    genvar gi, gl, gk;
    for (gi = 0; gi < CH; gi++) begin : g_ch
        logic signed [DW-1:0] reduced;

        if (MODE == POOL_MAX) begin : g_max
            // Balanced tree: level gl holds POOL_N>>gl partial maxima.
            for (gl = 0; gl <= LOG_N; gl++) begin : g_lvl
                logic signed [DW-1:0] vals [POOL_N>>gl];
                for (gk = 0; gk < (POOL_N >> gl); gk++) begin : g_node
                    if (gl == 0) begin : g_leaf
                        assign vals[gk] = din[gi][gk];
                    end else begin : g_cmp
                        assign vals[gk] = (g_lvl[gl-1].vals[2*gk] >= g_lvl[gl-1].vals[2*gk+1])
                                        ? g_lvl[gl-1].vals[2*gk]
                                        : g_lvl[gl-1].vals[2*gk+1];
                    end
                end
            end
            assign reduced = g_lvl[LOG_N].vals[0];
        end else begin : g_avg
            logic signed [SW-1:0] sum;
            logic signed [SW-1:0] shifted;

            // Sign-extended sum of the window; wide enough that it never overflows.
            always_comb begin
                sum = '0;
                for (int k = 0; k < POOL_N; k++) begin
                    sum = sum + SW'($signed(din[gi][k]));
                end
            end

            // Arithmetic shift floors toward minus infinity; the mean of DW-bit
            // values always fits back into DW bits.
            assign shifted = sum >>> LOG_N;
            assign reduced = shifted[DW-1:0];
        end

        assign pooled[gi] = ((RELU != 0) && (reduced < 0)) ? '0 : reduced;
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and sticky flags
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic          udf_reg, udf_next;
    logic          wr_fire;
    logic          rd_fire;

    // Status is decoded from the registered count only, so a same-cycle pop
    // never opens room for a write.
    assign full   = (count_reg == CW'(DEPTH));
    assign empty  = (count_reg == '0);
    assign wr_rdy = !full;
    assign rd_vld = !empty;
    assign count  = count_reg;
    assign ovf    = ovf_reg;
    assign udf    = udf_reg;

    // A frame clear discards every request in its cycle.
    assign wr_fire = wr_vld && !full  && !clr;
    assign rd_fire = rd_inc && !empty && !clr;

    // Next-state: advance pointers on accepted traffic, track occupancy, latch refusals.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        udf_next    = udf_reg;

        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            udf_next    = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (wr_vld && full) begin
                ovf_next = 1'b1;
            end
            if (rd_inc && empty) begin
                udf_next = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            udf_reg    <= udf_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [CH*DW-1:0] ram_rdata;

    pool_buffer_ram #(
        .W     (CH*DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire && !rst),
        .waddr (wr_ptr_reg),
        .wdata (pooled),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    assign dout = ram_rdata;

endmodule
